hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W). It drives the per-stage flush/stall bundle and the EX-stage forwarding selects. It also sequences multi-cycle instruction and data memory handshakes, including discarding a stale fetch that is in flight when a taken branch or jump redirects the PC. It sits beside the datapath and is the only source of `hazard_data_t`.

---
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: flush/stall bundle, EX forwarding selects and I/D memory handshake sequencing.
// Define HAZARD_PERF_EN to build the saturating stall/redirect performance counters.
package hazard_pkg;

   typedef struct packed {
      logic flush;
      logic stall;
   } stage_ctl_t;

   typedef struct packed {
      stage_ctl_t f;
      stage_ctl_t d;
      stage_ctl_t e;
      stage_ctl_t m;
   } hazard_data_t;

endpackage

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic              d_jump,
   input  logic [REG_AW-1:0] e_rs,
   input  logic [REG_AW-1:0] e_rt,
   input  logic [REG_AW-1:0] e_write_reg,
   input  logic              e_reg_write,
   input  logic              e_mem_to_reg,
   input  logic [REG_AW-1:0] m_write_reg,
   input  logic              m_reg_write,
   input  logic              m_branch,
   input  logic              m_zero,
   input  logic              m_mem_req,
   input  logic [REG_AW-1:0] w_write_reg,
   input  logic              w_reg_write,
   input  logic              i_data_ok,
   input  logic              d_data_ok,
   output hazard_data_t      hazard,
   output logic              pc_stall,
   output logic              redirect,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
`endif
);

   localparam hazard_data_t HAZ_RESET = 8'b1010_1010;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      IDROP = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         rst_q;
   hazard_data_t haz_c;
   logic         pc_stall_c;
   logic         redirect_c;
   logic [1:0]   fwd_a_c;
   logic [1:0]   fwd_b_c;
   logic         data_wait;
   logic         load_use;
   logic         br_taken;
   logic         m_fwd_ok;
   logic         w_fwd_ok;
   logic         unused_ok;

   // Write-enable is implied by mem_to_reg for loads, so it does not enter the load-use test.
   assign unused_ok = e_reg_write;

   assign data_wait = m_mem_req && !d_data_ok;
   assign load_use  = e_mem_to_reg && (e_write_reg != '0) &&
                      ((e_write_reg == d_rs) || (e_write_reg == d_rt));
   assign br_taken  = m_branch && m_zero;
   assign m_fwd_ok  = m_reg_write && (m_write_reg != '0);
   assign w_fwd_ok  = w_reg_write && (w_write_reg != '0);

   // State register; rst_q marks the cycle that shows the reset value.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= RUN;
         rst_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rst_q <= 1'b0;
      end
   end

   // Hazard resolution, one source at a time in priority order.
   always_comb begin
      haz_c      = '0;
      pc_stall_c = 1'b0;
      redirect_c = 1'b0;
      state_nxt  = RUN;

      if (data_wait) begin
         haz_c.f.stall = 1'b1;
         haz_c.d.stall = 1'b1;
         haz_c.e.stall = 1'b1;
         haz_c.m.flush = 1'b1;
         pc_stall_c    = 1'b1;
      end else if (load_use) begin
         haz_c.f.stall = 1'b1;
         haz_c.d.flush = 1'b1;
         pc_stall_c    = 1'b1;
      end else if (br_taken) begin
         haz_c.f.flush = 1'b1;
         haz_c.d.flush = 1'b1;
         haz_c.e.flush = 1'b1;
         redirect_c    = 1'b1;
      end else if (d_jump) begin
         haz_c.f.flush = 1'b1;
         redirect_c    = 1'b1;
      end else if (state == IDROP) begin
         haz_c.f.flush = 1'b1;
      end else if ((state == RUN) && !i_data_ok) begin
         haz_c.f.flush = 1'b1;
         pc_stall_c    = 1'b1;
      end

      // A stale fetch still in flight at redirect must be swallowed before the target is accepted.
      if (rst_q) begin
         state_nxt = RUN;
      end else if (data_wait) begin
         state_nxt = DWAIT;
      end else if ((redirect_c || (state == IDROP)) && !i_data_ok) begin
         state_nxt = IDROP;
      end else begin
         state_nxt = RUN;
      end
   end

   // EX operand forwarding, youngest producer first.
   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
      if (m_fwd_ok && (m_write_reg == e_rs)) begin
         fwd_a_c = 2'b10;
      end else if (w_fwd_ok && (w_write_reg == e_rs)) begin
         fwd_a_c = 2'b01;
      end
      if (m_fwd_ok && (m_write_reg == e_rt)) begin
         fwd_b_c = 2'b10;
      end else if (w_fwd_ok && (w_write_reg == e_rt)) begin
         fwd_b_c = 2'b01;
      end
   end

   assign hazard    = rst_q ? HAZ_RESET : haz_c;
   assign pc_stall  = !rst_q && pc_stall_c;
   assign redirect  = !rst_q && redirect_c;
   assign fwd_a_sel = rst_q ? 2'b00 : fwd_a_c;
   assign fwd_b_sel = rst_q ? 2'b00 : fwd_b_c;

`ifdef HAZARD_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (pc_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (redirect && (flush_events != '1)) begin
            flush_events <= flush_events + CNT_W'(1);
         end
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
// Build with HAZARD_PERF_EN defined to also check the performance counters.
module tb_hazard_ctrl;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;
   localparam int S_RUN   = 0;
   localparam int S_DWAIT = 1;
   localparam int S_IDROP = 2;
   localparam logic [7:0] H_NONE   = 8'b0000_0000;
   localparam logic [7:0] H_RESET  = 8'b1010_1010;
   localparam logic [7:0] H_DWAIT  = 8'b0101_0110;
   localparam logic [7:0] H_LDUSE  = 8'b0110_0000;
   localparam logic [7:0] H_BRANCH = 8'b1010_1000;
   localparam logic [7:0] H_FFLUSH = 8'b1000_0000;

   logic              clk;
   logic              resetn;
   logic [REG_AW-1:0] d_rs, d_rt, e_rs, e_rt, e_write_reg, m_write_reg, w_write_reg;
   logic              d_jump, e_reg_write, e_mem_to_reg;
   logic              m_reg_write, m_branch, m_zero, m_mem_req, w_reg_write;
   logic              i_data_ok, d_data_ok;
   logic [7:0]        hazard;
   logic              pc_stall, redirect;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0]  stall_cycles, flush_events;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state: pipeline mode, reset-display cycle, event tallies.
   int               m_state   = S_RUN;
   logic             m_rst     = 1'b1;
   logic [CNT_W-1:0] m_stalls  = '0;
   logic [CNT_W-1:0] m_flushes = '0;

   hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_jump       (d_jump),
      .e_rs         (e_rs),
      .e_rt         (e_rt),
      .e_write_reg  (e_write_reg),
      .e_reg_write  (e_reg_write),
      .e_mem_to_reg (e_mem_to_reg),
      .m_write_reg  (m_write_reg),
      .m_reg_write  (m_reg_write),
      .m_branch     (m_branch),
      .m_zero       (m_zero),
      .m_mem_req    (m_mem_req),
      .w_write_reg  (w_write_reg),
      .w_reg_write  (w_reg_write),
      .i_data_ok    (i_data_ok),
      .d_data_ok    (d_data_ok),
      .hazard       (hazard),
      .pc_stall     (pc_stall),
      .redirect     (redirect),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected bundle for the current inputs: the highest-priority active rule picks a fixed pattern.
   function automatic void model_expect(output logic [7:0] hz, output logic ps, output logic rd);
      hz = H_NONE;
      ps = 1'b0;
      rd = 1'b0;
      if (m_rst) hz = H_RESET;
      else if (m_mem_req && !d_data_ok) begin hz = H_DWAIT; ps = 1'b1; end
      else if (e_mem_to_reg && e_write_reg != 0 && (e_write_reg == d_rs || e_write_reg == d_rt)) begin
         hz = H_LDUSE; ps = 1'b1;
      end
      else if (m_branch && m_zero) begin hz = H_BRANCH; rd = 1'b1; end
      else if (d_jump) begin hz = H_FFLUSH; rd = 1'b1; end
      else if (m_state == S_IDROP) hz = H_FFLUSH;
      else if (m_state == S_RUN && !i_data_ok) begin hz = H_FFLUSH; ps = 1'b1; end
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] src);
      if (m_rst) return 2'b00;
      if (m_reg_write && m_write_reg != 0 && m_write_reg == src) return 2'b10;
      if (w_reg_write && w_write_reg != 0 && w_write_reg == src) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk) begin : model_seq
      logic [7:0] hz;
      logic       ps, rd;
      model_expect(hz, ps, rd);
      if (!resetn) begin
         m_state   <= S_RUN;
         m_rst     <= 1'b1;
         m_stalls  <= '0;
         m_flushes <= '0;
      end else begin
         if (ps && m_stalls != '1) m_stalls <= m_stalls + CNT_W'(1);
         if (rd && m_flushes != '1) m_flushes <= m_flushes + CNT_W'(1);
         if (m_rst) m_state <= S_RUN;
         else if (m_mem_req && !d_data_ok) m_state <= S_DWAIT;
         else if ((rd || m_state == S_IDROP) && !i_data_ok) m_state <= S_IDROP;
         else m_state <= S_RUN;
         m_rst <= 1'b0;
      end
   end

   task automatic idle_inputs();
      d_rs = '0; d_rt = '0; e_rs = '0; e_rt = '0;
      e_write_reg = '0; m_write_reg = '0; w_write_reg = '0;
      d_jump = 1'b0; e_reg_write = 1'b0; e_mem_to_reg = 1'b0;
      m_reg_write = 1'b0; m_branch = 1'b0; m_zero = 1'b0; m_mem_req = 1'b0;
      w_reg_write = 1'b0; i_data_ok = 1'b1; d_data_ok = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      m_reg_write = 1'b1; m_write_reg = 5'd5; e_rs = 5'd5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (hazard !== H_RESET) begin errors++; $display("FAIL reset_hazard: got %b expected %b", hazard, H_RESET); end
      checks++; if (pc_stall !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL reset_pc: got pc_stall=%b redirect=%b expected 0 0", pc_stall, redirect); end
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b expected 00", fwd_a_sel); end
`ifdef HAZARD_PERF_EN
      checks++; if (stall_cycles !== '0 || flush_events !== '0) begin errors++; $display("FAIL reset_counters: got %0d %0d expected 0 0", stall_cycles, flush_events); end
`endif
      @(posedge clk); #1;
      resetn = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (hazard !== H_NONE || pc_stall !== 1'b0) begin errors++; $display("FAIL reset_release: got %b/%b expected %b/0", hazard, pc_stall, H_NONE); end
   endtask

   task automatic test_forwarding();
      @(posedge clk); #1;
      idle_inputs();
      m_reg_write = 1'b1; m_write_reg = 5'd5; w_reg_write = 1'b1; w_write_reg = 5'd5;
      e_rs = 5'd5; e_rt = 5'd0;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_m_wins: got %b %b expected 10 00", fwd_a_sel, fwd_b_sel); end
      @(posedge clk); #1;
      m_write_reg = 5'd6;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b expected 01", fwd_a_sel); end
      @(posedge clk); #1;
      e_rt = 5'd6;
      @(negedge clk);
      checks++; if (fwd_b_sel !== 2'b10 || fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_b_m: got %b %b expected 01 10", fwd_a_sel, fwd_b_sel); end
      @(posedge clk); #1;
      m_write_reg = 5'd0; w_write_reg = 5'd0; e_rs = 5'd0; e_rt = 5'd0;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b %b expected 00 00", fwd_a_sel, fwd_b_sel); end
   endtask

   task automatic test_load_use();
      @(posedge clk); #1;
      idle_inputs();
      e_mem_to_reg = 1'b1; e_reg_write = 1'b1; e_write_reg = 5'd8; d_rt = 5'd8;
      @(negedge clk);
      checks++; if (hazard !== H_LDUSE || pc_stall !== 1'b1) begin errors++; $display("FAIL ldu_stall: got %b/%b expected %b/1", hazard, pc_stall, H_LDUSE); end
      @(posedge clk); #1;
      idle_inputs();
      m_reg_write = 1'b1; m_write_reg = 5'd8; m_mem_req = 1'b1; e_rs = 5'd8; e_rt = 5'd8;
      @(negedge clk);
      checks++; if (hazard !== H_NONE || pc_stall !== 1'b0) begin errors++; $display("FAIL ldu_once: got %b/%b expected %b/0", hazard, pc_stall, H_NONE); end
      checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin errors++; $display("FAIL ldu_fwd: got %b %b expected 10 10", fwd_a_sel, fwd_b_sel); end
      @(posedge clk); #1;
      idle_inputs();
      e_mem_to_reg = 1'b1; e_write_reg = 5'd0; d_rs = 5'd0; d_jump = 1'b1;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || redirect !== 1'b1) begin errors++; $display("FAIL ldu_r0_jump: got %b/%b expected %b/1", hazard, redirect, H_FFLUSH); end
      @(posedge clk); #1;
      idle_inputs();
      e_mem_to_reg = 1'b1; e_write_reg = 5'd3; d_rs = 5'd3; d_jump = 1'b1;
      @(negedge clk);
      checks++; if (hazard !== H_LDUSE || redirect !== 1'b0) begin errors++; $display("FAIL ldu_over_jump: got %b/%b expected %b/0", hazard, redirect, H_LDUSE); end
   endtask

   task automatic test_data_wait();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         idle_inputs();
         m_mem_req = 1'b1; d_data_ok = 1'b0;
         @(negedge clk);
         checks++; if (hazard !== H_DWAIT || pc_stall !== 1'b1) begin errors++; $display("FAIL dwait_%0d: got %b/%b expected %b/1", i, hazard, pc_stall, H_DWAIT); end
      end
      // Completion cycle: still in DWAIT, so a missing instruction does not stall here.
      @(posedge clk); #1;
      d_data_ok = 1'b1; i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_NONE || pc_stall !== 1'b0) begin errors++; $display("FAIL dwait_done: got %b/%b expected %b/0", hazard, pc_stall, H_NONE); end
      @(posedge clk); #1;
      m_mem_req = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b1) begin errors++; $display("FAIL dwait_back_run: got %b/%b expected %b/1", hazard, pc_stall, H_FFLUSH); end
      @(posedge clk); #1;
      idle_inputs();
      m_mem_req = 1'b1; i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b1) begin errors++; $display("FAIL dwait_same_cycle: got %b/%b expected %b/1", hazard, pc_stall, H_FFLUSH); end
      @(posedge clk); #1;
      m_mem_req = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b1) begin errors++; $display("FAIL dwait_never_entered: got %b/%b expected %b/1", hazard, pc_stall, H_FFLUSH); end
   endtask

   task automatic test_branch_fetch();
      @(posedge clk); #1;
      idle_inputs();
      m_branch = 1'b1; m_zero = 1'b1; i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_BRANCH || redirect !== 1'b1 || pc_stall !== 1'b0) begin errors++; $display("FAIL br_redirect: got %b/%b/%b expected %b/1/0", hazard, redirect, pc_stall, H_BRANCH); end
      @(posedge clk); #1;
      idle_inputs();
      i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL idrop_wait: got %b/%b/%b expected %b/0/0", hazard, pc_stall, redirect, H_FFLUSH); end
      @(posedge clk); #1;
      i_data_ok = 1'b1;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b0) begin errors++; $display("FAIL idrop_drop: got %b/%b expected %b/0", hazard, pc_stall, H_FFLUSH); end
      @(posedge clk); #1;
      i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b1) begin errors++; $display("FAIL idrop_exit: got %b/%b expected %b/1", hazard, pc_stall, H_FFLUSH); end
      @(posedge clk); #1;
      idle_inputs();
      d_jump = 1'b1;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || redirect !== 1'b1 || pc_stall !== 1'b0) begin errors++; $display("FAIL jump_ready: got %b/%b/%b expected %b/1/0", hazard, redirect, pc_stall, H_FFLUSH); end
      @(posedge clk); #1;
      idle_inputs();
      i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL jump_no_idrop: got pc_stall=%b expected 1", pc_stall); end
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         idle_inputs();
         m_mem_req = 1'b1; d_data_ok = 1'b0;
         @(negedge clk);
         checks++; if (hazard !== H_DWAIT) begin errors++; $display("FAIL rmw_dwait_%0d: got %b expected %b", i, hazard, H_DWAIT); end
      end
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      m_mem_req = 1'b0; d_data_ok = 1'b1; i_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (hazard !== H_RESET || pc_stall !== 1'b0) begin errors++; $display("FAIL rmw_reset: got %b/%b expected %b/0", hazard, pc_stall, H_RESET); end
`ifdef HAZARD_PERF_EN
      checks++; if (stall_cycles !== '0 || flush_events !== '0) begin errors++; $display("FAIL rmw_counters: got %0d %0d expected 0 0", stall_cycles, flush_events); end
`endif
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (hazard !== H_FFLUSH || pc_stall !== 1'b1) begin errors++; $display("FAIL rmw_run: got %b/%b expected %b/1", hazard, pc_stall, H_FFLUSH); end
   endtask

   task automatic test_random();
      logic [7:0] hz;
      logic       ps, rd;
      logic [1:0] fa, fb;
      for (int n = 0; n < 1500; n++) begin
         @(posedge clk); #1;
         d_rs = REG_AW'($urandom_range(0, 3));
         d_rt = REG_AW'($urandom_range(0, 3));
         e_rs = REG_AW'($urandom_range(0, 3));
         e_rt = REG_AW'($urandom_range(0, 3));
         e_write_reg = REG_AW'($urandom_range(0, 3));
         m_write_reg = REG_AW'($urandom_range(0, 3));
         w_write_reg = REG_AW'($urandom_range(0, 3));
         e_reg_write = 1'($urandom_range(0, 1));
         m_reg_write = 1'($urandom_range(0, 1));
         w_reg_write = 1'($urandom_range(0, 1));
         m_zero = 1'($urandom_range(0, 1));
         e_mem_to_reg = ($urandom_range(0, 3) == 0);
         m_mem_req = (m_state == S_DWAIT) ? 1'b1 : ($urandom_range(0, 3) == 0);
         d_data_ok = ($urandom_range(0, 2) != 0);
         m_branch = m_mem_req ? 1'b0 : ($urandom_range(0, 3) == 0);
         d_jump = ($urandom_range(0, 5) == 0);
         i_data_ok = ($urandom_range(0, 2) != 0);
         // Behind a redirect the younger stages hold only bubbles.
         if (m_state == S_IDROP) begin
            m_mem_req = 1'b0; e_mem_to_reg = 1'b0; m_branch = 1'b0; d_jump = 1'b0;
         end
         @(negedge clk);
         model_expect(hz, ps, rd);
         fa = exp_fwd(e_rs);
         fb = exp_fwd(e_rt);
         checks++; if (hazard !== hz) begin errors++; $display("FAIL rnd_hazard n=%0d: got %b expected %b", n, hazard, hz); end
         checks++; if (pc_stall !== ps) begin errors++; $display("FAIL rnd_pc_stall n=%0d: got %b expected %b", n, pc_stall, ps); end
         checks++; if (redirect !== rd) begin errors++; $display("FAIL rnd_redirect n=%0d: got %b expected %b", n, redirect, rd); end
         checks++; if (fwd_a_sel !== fa) begin errors++; $display("FAIL rnd_fwd_a n=%0d: got %b expected %b", n, fwd_a_sel, fa); end
         checks++; if (fwd_b_sel !== fb) begin errors++; $display("FAIL rnd_fwd_b n=%0d: got %b expected %b", n, fwd_b_sel, fb); end
      end
`ifdef HAZARD_PERF_EN
      checks++; if (stall_cycles !== m_stalls) begin errors++; $display("FAIL rnd_stall_cycles: got %0d expected %0d", stall_cycles, m_stalls); end
      checks++; if (flush_events !== m_flushes) begin errors++; $display("FAIL rnd_flush_events: got %0d expected %0d", flush_events, m_flushes); end
`endif
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_data_wait();
      test_branch_fetch();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
